// File: rtl/reg_write_arbiter_if.sv
// Bus bundle between write requesters and the shared config-register arbiter.
// The master side drives requests; the slave side (the arbiter) grants them
// and publishes the shared register state.
interface reg_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      reg_q;
  logic [OW-1:0]         reg_owner;
  logic                  upd;
  logic                  busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, reg_q, reg_owner, upd, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, reg_q, reg_owner, upd, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for one shared, reset-initialised config register.
// One winner per write slot; after each write the block sits in COOLDOWN for
// HOLD cycles before it will grant again.
module reg_write_arbiter #(
  parameter int          NREQ  = 4,
  parameter int          WIDTH = 8,
  parameter int unsigned INIT  = 32'h05,
  parameter int          HOLD  = 2
) (
  input logic               clk,
  input logic               rst,
  reg_write_arbiter_if.slave bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One extra bit so ptr + offset can exceed NREQ-1 before wrapping.
  localparam int IW = OW + 1;
  localparam logic [WIDTH-1:0] INIT_V  = WIDTH'(INIT);
  localparam logic [3:0]       HOLD_M1 = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_COOLDOWN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic             upd_q, upd_d;
  logic             busy_q, busy_d;

  logic             found_s;
  logic [OW-1:0]    win_s;
  logic [IW-1:0]    idx_s;
  logic [IW-1:0]    nxt_s;
  logic             grant_s;

  // Rotating priority search: first valid requester at or after ptr.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = IW'(ptr_q) + IW'(k);
      if (idx_s >= IW'(NREQ)) begin
        idx_s = idx_s - IW'(NREQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && bus.req_valid[idx_s[OW-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[OW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant only in IDLE and never while reset is asserted, so a handshake
  // seen by a requester always corresponds to a committed write.
  always_comb begin
    grant_s = (state_q == S_IDLE) && found_s && !rst;
    if (grant_s) begin
      bus.req_ready = NREQ'(1) << win_s;
    end else begin
      bus.req_ready = '0;
    end
  end

  // Next-state, register load, pointer advance and cool-down counting.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    owner_d = owner_q;
    upd_d   = 1'b0;
    nxt_s   = IW'(win_s) + IW'(1);
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          val_d   = bus.req_data[win_s*WIDTH +: WIDTH];
          owner_d = win_s;
          upd_d   = 1'b1;
          // Winner drops to lowest priority for the next slot.
          if (nxt_s == IW'(NREQ)) begin
            ptr_d = '0;
          end else begin
            ptr_d = nxt_s[OW-1:0];
          end
          if (HOLD > 0) begin
            state_d = S_COOLDOWN;
            cnt_d   = HOLD_M1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COOLDOWN: begin
        // Counter loaded with HOLD-1 gives exactly HOLD cycles here.
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d == S_COOLDOWN);
  end

  // State and output registers; synchronous reset overrides any grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= 4'd0;
      val_q   <= INIT_V;
      owner_q <= '0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      owner_q <= owner_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.reg_q     = val_q;
  assign bus.reg_owner = owner_q;
  assign bus.upd       = upd_q;
  assign bus.busy      = busy_q;
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter for a shared, reset-initialised configuration register. Up to NREQ requesters present a write value with a valid/ready handshake. The block selects one winner per write slot, loads the shared register, and enforces a programmable cool-down between successive writes. It sits in front of the config-register datapath so that multiple masters can update one register without collisions.

## Interface
- NREQ, default 4: number of requesters, 2..8.
- WIDTH, default 8: register width.
- INIT, default 'h05: register value after reset, truncated to WIDTH.
- HOLD, default 2: idle cycles forced after each write, 0..15.
- clk, input, 1: clock, rising-edge.
- rst, input, 1: reset, synchronous, active-high.
- req_valid, input, NREQ: per-requester write request.
- req_data, input, NREQ*WIDTH: requester i's data occupies bits [i*WIDTH +: WIDTH].
- req_ready, output, NREQ: one-hot grant, combinational, at most one bit set.
- reg_q, output, WIDTH: shared register value.
- reg_owner, output, clog2(NREQ) (minimum 1): index of the last writer.
- upd, output, 1: one-cycle pulse in the cycle after a write, aligned with the new reg_q.
- busy, output, 1: high while in COOLDOWN.

## Operation
- State machine has two states: IDLE and COOLDOWN. The reset state is IDLE.
- Round-robin pointer ptr (clog2(NREQ) bits) resets to 0.
- IDLE:
  - Search starts at ptr and wraps modulo NREQ. The first i with req_valid[i]=1 is the winner.
  - req_ready[winner]=1 in the same cycle. The handshake completes in that cycle.
  - At the next edge: reg_q <= req_data[winner], reg_owner <= winner, upd <= 1, ptr <= (winner+1) mod NREQ.
  - Next state is COOLDOWN if HOLD>0, otherwise IDLE.
- No valid request in IDLE: req_ready=0, ptr unchanged, reg_q holds.
- COOLDOWN:
  - req_ready=0 and busy=1.
  - Down-counter loaded with HOLD-1 on entry; returns to IDLE when it reads 0. This gives exactly HOLD cycles in COOLDOWN.
- Requesters must hold req_valid and req_data stable until ready. Dropping valid before ready is allowed; the request is simply lost and is not an error.
- Multiple simultaneous valids: only the winner is served. The others remain pending and are served in later slots in rotation order, which prevents starvation.
- reg_q changes only on a granted write or on reset.

## Timing
- Reset values: reg_q=INIT, reg_owner=0, upd=0, busy=0, req_ready=0 (state IDLE with no valid). ptr=0, counter=0.
- Reset mid-operation has priority over everything:
  - A grant shown in the same cycle as rst=1 is not committed; reg_q takes INIT.
  - COOLDOWN is aborted.
- Grant-to-data latency is 1 cycle: reg_q shows the new value on the cycle after req_ready, and upd=1 in that same cycle.
- Write throughput is at most 1 write per HOLD+1 cycles. With HOLD=0, back-to-back grants every cycle are legal.
- busy rises the cycle after a grant and falls HOLD cycles later. req_ready may assert in the first cycle busy=0.
- ptr wraps from NREQ-1 to 0.
- A requester that wins and keeps valid high competes again at the next slot, but with the lowest priority.

## Test plan
- **Reset:** assert rst 2 cycles, then release → reg_q=8'h05, upd=0, busy=0, req_ready=0, reg_owner=0.
- **Single requester** (HOLD=2): req_valid=4'b0100, data2=8'hA7 → req_ready=4'b0100 in the same cycle. Next cycle reg_q=8'hA7, reg_owner=2, upd=1, busy=1. busy stays high 2 cycles, then req_ready is available again.
- **Round-robin fairness:** all 4 valid and held, data_i=8'h10+i → grant order 0,1,2,3,0, with reg_q values 10,11,12,13,10. Each grant is separated by 3 cycles.
- **HOLD=0 back-to-back:** req_valid=4'b1001 held → grants alternate 0,3,0,3 on consecutive cycles, with upd high every cycle.
- **Reset mid-COOLDOWN:** grant req1 with data 8'hFF, then assert rst during busy → next cycle reg_q=8'h05, busy=0, ptr=0. After release, with all valid, req0 wins first.
- **Withdrawn request:** req2 valid only during COOLDOWN, then dropped → no grant, reg_q unchanged, ptr unchanged.
